mips_multicycle_ctrl: RTL and testbench

Control FSM that sequences the MIPS datapath as a multi-cycle machine over one unified, variable-latency memory port. It replaces the combinational main-decoder/ALU_Control path of the single-cycle core. Each cycle it drives the datapath mux selects, register-file and memory strobes, and PC/IR write enables, and it stalls on a memory-ready handshake. It also retires-counts instructions and flags illegal opcodes and memory timeouts.

---
 rtl/mips_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for a multi-cycle MIPS datapath that shares one memory port
// with variable latency. The FSM drives the datapath mux selects, the
// register-file and memory strobes, and the PC/IR write enables. It stalls
// on mem_ready, counts retired instructions, flags undecodable opcodes, and
// halts when a memory access waits too long.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   op, funct          opcode and R-type function field from the IR
//   mem_ready          memory completes the current read or write this cycle
//   PCWrite ..PCSource datapath control strobes and mux selects (Moore,
//                      except IRWrite/PCWrite in FETCH, which follow mem_ready)
//   state              current state encoding, for debug
//   retired            number of instructions completed since reset
//   illegal_op         one-cycle pulse in DECODE on an undecodable opcode
//   mem_timeout        sticky timeout flag; the FSM sits in HALT until reset
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // The stall that would bring the wait count up to MAX_WAIT is the one
    // that times out; mem_ready in that same cycle still completes normally.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               timed_out;

    // Shared stall handling for FETCH, MEMRD and MEMWR: timeout if this stall
    // reaches the limit, otherwise keep counting. Any exit clears the count.
    assign timed_out = !mem_ready && (wait_q == WAIT_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement can infer a latch.
        state_d       = state_q;
        wait_d        = '0;
        retired_d     = retired_q;
        mem_timeout_d = mem_timeout_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 2'b00;
        RegDst        = 2'b00;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;            // PC + 4
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d       = S_HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;            // branch target into ALUOut
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                IorD     = 1'b1;
                MemRead  = (state_q == S_MEMRD);
                MemWrite = (state_q == S_MEMWR);
                if (mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timed_out) begin
                    state_d       = S_HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;           // $31 gets the already-advanced PC
                MemtoReg = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_JR: begin
                ALUSrcA  = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_HALT;           // HALT holds until reset
            end
        endcase

        // An instruction retires when a completed sequence returns to FETCH;
        // stalls, illegal-op aborts and HALT never count.
        if (state_d == S_FETCH &&
            !(state_q inside {S_FETCH, S_DECODE, S_HALT})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            retired_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q       <= state_d;
            wait_q        <= wait_d;
            retired_q     <= retired_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign retired     = retired_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Drives instruction streams through the control FSM. A reference model
// builds the expected per-cycle state path of each instruction from its
// class and memory stall counts, and derives the expected control strobes
// of each cycle from the state's output table.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 32;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]       MemtoReg, RegDst;
    logic             RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal_op;
    logic             mem_timeout;

    mips_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .retired     (retired),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    ctrl_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, illegal_op};

    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_ret;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08};
    endfunction

    // Expected strobes of each state, straight from the output table.
    function automatic ctrl_t exp_ctrl(input int st, input bit rdy, input logic [5:0] o);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                      c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.alu_src_b = 2'b11; c.illegal = !is_legal(o); end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.iord = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            5:  begin c.mem_write = 1; c.iord = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: begin c.reg_write = 1; end
            12: begin c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                      c.pc_write = 1; c.pc_source = 2'b10; end
            13: begin c.alu_src_a = 1; c.pc_write = 1; c.pc_source = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // One clock: drive mem_ready, check everything mid-cycle, advance.
    task automatic step(input int exp_st, input bit rdy, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check($sformatf("%s.state", tag), 64'(state), 64'(exp_st));
        check($sformatf("%s.ctrl", tag), 64'(obs), 64'(exp_ctrl(exp_st, rdy, op)));
        check($sformatf("%s.retired", tag), 64'(retired), 64'(exp_ret));
        check($sformatf("%s.timeout", tag), 64'(mem_timeout), 64'(exp_st == 15));
        @(posedge clk);
        #1;
    endtask

    // Expected path of one instruction: FETCH with sf stalls, DECODE, then the
    // class-specific states; sm stalls on the data access of lw/sw.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int sf, input int sm, input string tag);
        int sq[$];
        bit rq[$];
        bit retires;
        op    = o;
        funct = f;
        for (int i = 0; i < sf; i++) begin sq.push_back(0); rq.push_back(0); end
        sq.push_back(0); rq.push_back(1);
        sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
        retires = 1;
        case (o)
            6'h23, 6'h2b: begin
                sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < sm; i++) begin
                    sq.push_back(o == 6'h23 ? 3 : 5); rq.push_back(0);
                end
                sq.push_back(o == 6'h23 ? 3 : 5); rq.push_back(1);
                if (o == 6'h23) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
            end
            6'h00: begin
                if (f == 6'h08) begin sq.push_back(13); rq.push_back(1'($urandom_range(0, 1))); end
                else begin
                    sq.push_back(6); rq.push_back(1'($urandom_range(0, 1)));
                    sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
                end
            end
            6'h04: begin sq.push_back(8);  rq.push_back(1'($urandom_range(0, 1))); end
            6'h02: begin sq.push_back(9);  rq.push_back(1'($urandom_range(0, 1))); end
            6'h03: begin sq.push_back(12); rq.push_back(1'($urandom_range(0, 1))); end
            6'h08: begin
                sq.push_back(10); rq.push_back(1'($urandom_range(0, 1)));
                sq.push_back(11); rq.push_back(1'($urandom_range(0, 1)));
            end
            default: retires = 0;
        endcase
        for (int i = 0; i < sq.size(); i++) step(sq[i], rq[i], $sformatf("%s[%0d]", tag, i));
        if (retires) exp_ret = exp_ret + 1;
    endtask

    initial begin
        logic [5:0] ro, rf;
        reset     = 1'b1;
        mem_ready = 1'b0;
        op        = 6'h00;
        funct     = 6'h00;
        exp_ret   = '0;

        // Reset state
        @(negedge clk);
        check("rst.state", 64'(state), 64'd0);
        check("rst.retired", 64'(retired), 64'd0);
        check("rst.timeout", 64'(mem_timeout), 64'd0);
        check("rst.ctrl", 64'(obs), 64'(exp_ctrl(0, 0, op)));
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed: the main instruction classes and the stall boundary
        run_instr(6'h23, 6'h00, 0, 0, "lw");
        run_instr(6'h2b, 6'h00, 0, 3, "sw_stall3");
        run_instr(6'h00, 6'h20, 0, 0, "add");
        run_instr(6'h00, 6'h08, 0, 0, "jr");
        run_instr(6'h04, 6'h00, 0, 0, "beq");
        run_instr(6'h03, 6'h00, 0, 0, "jal");
        run_instr(6'h3f, 6'h00, 0, 0, "illegal");
        run_instr(6'h08, 6'h00, MAX_WAIT - 1, 0, "addi_fstall_max");
        run_instr(6'h23, 6'h00, 1, MAX_WAIT - 1, "lw_mstall_max");
        run_instr(6'h02, 6'h00, 2, 0, "j");

        // Randomized instruction stream; stalls stay below the limit
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 8))
                0: ro = 6'h23;
                1: ro = 6'h2b;
                2, 3: ro = 6'h00;
                4: ro = 6'h04;
                5: ro = 6'h02;
                6: ro = 6'h03;
                7: ro = 6'h08;
                default: ro = 6'($urandom);
            endcase
            rf = ($urandom_range(0, 1) == 1) ? 6'h08 : 6'($urandom);
            run_instr(ro, rf, int'($urandom_range(0, MAX_WAIT - 1)),
                      int'($urandom_range(0, MAX_WAIT - 1)), $sformatf("rnd%0d", n));
        end

        // Fetch timeout: MAX_WAIT stall cycles, then HALT regardless of mem_ready
        op = 6'h23;
        for (int i = 0; i < MAX_WAIT; i++) step(0, 0, $sformatf("fto_fetch%0d", i));
        for (int i = 0; i < 3; i++) step(15, 1'($urandom_range(0, 1)), $sformatf("fto_halt%0d", i));

        // Asynchronous reset in the middle of a cycle
        #3 reset = 1'b1;
        #1;
        check("async_rst.state", 64'(state), 64'd0);
        check("async_rst.timeout", 64'(mem_timeout), 64'd0);
        check("async_rst.retired", 64'(retired), 64'd0);
        exp_ret = '0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Store timeout: data access never completes
        op = 6'h2b;
        step(0, 1, "sto_fetch");
        step(1, 0, "sto_decode");
        step(2, 0, "sto_memadr");
        for (int i = 0; i < MAX_WAIT; i++) step(5, 0, $sformatf("sto_memwr%0d", i));
        for (int i = 0; i < 2; i++) step(15, 1'($urandom_range(0, 1)), $sformatf("sto_halt%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
